cpu_seq: RTL

CPU_SEQ -- requirements
Module: cpu_seq

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/cpu_seq.sv | 113 +++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU sequencer and its sibling blocks.
// Holds the default address/instruction widths, the sequencer state
// encoding and the opcode values the instruction decoder works from.
package cpu_pkg;

  localparam int AW_DEF = 8;
  localparam int IW_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_t;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_STA = 4'd3;
  localparam logic [3:0] OP_LDI = 4'd4;
  localparam logic [3:0] OP_OUT = 4'd5;
  localparam logic [3:0] OP_IN  = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_JC  = 4'd8;
  localparam logic [3:0] OP_JNC = 4'd9;
  localparam logic [3:0] OP_JZ  = 4'd10;
  localparam logic [3:0] OP_JNZ = 4'd11;
  localparam logic [3:0] OP_HLT = 4'd12;

endpackage

// File: rtl/cpu_seq.sv
// cpu_seq: instruction sequencer for the lab CPU.
// Walks IDLE -> FETCH -> EXEC, fetching one instruction word per FETCH over
// a req/ack handshake, presenting the opcode to a sibling decoder and the
// immediate to the datapath, and updating the program counter from the
// decoder's jump/halt verdict during the single EXEC cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   run, step, clr      start level, single-step level, synchronous clear
//   imem_req/addr       fetch request and address (address = pc)
//   imem_ack/rdata      fetch completion and fetched word
//   ins, imm            opcode and immediate straight from the IR
//   exec_en             execute strobe, high only in EXEC
//   dec_jump, dec_hlt   decoder verdicts for the instruction in the IR
//   pc, halted, icount  program counter, HALT flag, retired-instruction count
module cpu_seq
  import cpu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          step,
  input  logic          clr,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic [3:0]    ins,
  output logic [AW-1:0] imm,
  output logic          exec_en,
  input  logic          dec_jump,
  input  logic          dec_hlt,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic [15:0]   icount
);

  state_t        state_q, state_d;
  logic          started_q;
  logic [AW-1:0] pc_q;
  logic [IW-1:0] ir_q;
  logic [15:0]   icount_q;

  // State register. started_q stays low for the first edge after reset
  // release so that the first fetch cannot happen on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  // Next-state logic. Halt beats step; clr overrides everything, including
  // an ack arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (run && started_q) state_d = ST_FETCH;
      ST_FETCH: if (imem_ack) state_d = ST_EXEC;
      ST_EXEC: begin
        if (dec_hlt)   state_d = ST_HALT;
        else if (step) state_d = ST_IDLE;
        else           state_d = ST_FETCH;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
    if (clr) state_d = ST_IDLE;
  end

  // Output decode: purely from state, so reset drops these immediately.
  always_comb begin
    imem_req = (state_q == ST_FETCH);
    exec_en  = (state_q == ST_EXEC);
    halted   = (state_q == ST_HALT);
  end

  // Program counter, instruction register and retired count. The IR only
  // loads on an ack inside FETCH; a halting EXEC still retires but keeps pc
  // on the halt instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      ir_q     <= '0;
      icount_q <= '0;
    end else if (clr) begin
      pc_q     <= '0;
      ir_q     <= '0;
      icount_q <= '0;
    end else if (state_q == ST_FETCH && imem_ack) begin
      ir_q <= imem_rdata;
    end else if (state_q == ST_EXEC) begin
      if (icount_q != 16'hFFFF) icount_q <= icount_q + 16'd1;
      if (!dec_hlt) begin
        if (dec_jump) pc_q <= ir_q[AW-1:0];
        else          pc_q <= pc_q + AW'(1);
      end
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign icount    = icount_q;
  assign ins       = ir_q[IW-1:IW-4];
  assign imm       = ir_q[AW-1:0];

endmodule
